// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM state, R/W and ACK encodings for the I2C master and slave
package i2c_pkg;
   localparam logic [3:0] IDLE      = 4'd0;
   localparam logic [3:0] ADDR      = 4'd1;
   localparam logic [3:0] ADDR_ACK  = 4'd2;
   localparam logic [3:0] PTR       = 4'd3;
   localparam logic [3:0] PTR_ACK   = 4'd4;
   localparam logic [3:0] WRITE     = 4'd5;
   localparam logic [3:0] WRITE_ACK = 4'd6;
   localparam logic [3:0] READ      = 4'd7;
   localparam logic [3:0] READ_ACK  = 4'd8;
   localparam logic [3:0] IGNORE    = 4'd9;
   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;
   localparam logic ACK  = 1'b0;
   localparam logic NACK = 1'b1;
endpackage

// File: rtl/i2c_sync_edge.sv
// i2c_sync_edge: 2-flop synchronizer plus a third flop for rise/fall detection
module i2c_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic q,
   output logic rise,
   output logic fall
);
   logic [2:0] s;
   // Bus lines idle high, so reset to 1 to avoid a spurious edge
   always_ff @(posedge clk) s <= rst ? 3'b111 : {s[1:0], din};
   assign q    = s[1];
   assign rise = s[1] & ~s[2];
   assign fall = ~s[1] & s[2];
endmodule

// File: rtl/i2c_slave.sv
// i2c_slave: I2C target with an auto-incrementing pointer into a small register file
module i2c_slave
   import i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR = 7'h01,
   parameter int NUM_REGS = 4,
   localparam int IW = $clog2(NUM_REGS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sclk,
   inout  wire                   sda,
   output logic [8*NUM_REGS-1:0] regs_flat,
   output logic                  wr_strobe,
   output logic [IW-1:0]         wr_index,
   output logic                  busy
);
   logic scl_q, scl_rise, scl_fall, sda_q, sda_rise, sda_fall;
   logic [3:0] state, bit_cnt;
   logic [7:0] shreg, data, cur;
   logic [IW-1:0] ptr;
   logic oe, start, stop, last;

   i2c_sync_edge u_scl (.clk(clk), .rst(rst), .din(sclk), .q(scl_q), .rise(scl_rise), .fall(scl_fall));
   i2c_sync_edge u_sda (.clk(clk), .rst(rst), .din(sda), .q(sda_q), .rise(sda_rise), .fall(sda_fall));

   // An sda edge coinciding with an sclk edge is a data bit, not START/STOP
   assign start = sda_fall & scl_q & ~scl_rise;
   assign stop  = sda_rise & scl_q & ~scl_rise;
   assign data  = {shreg[6:0], sda_q};
   assign cur   = regs_flat[{ptr, 3'b000} +: 8];
   assign last  = scl_rise && bit_cnt == 4'd7;
   assign sda   = oe ? 1'b0 : 1'bz;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         bit_cnt   <= 4'd0;
         shreg     <= 8'd0;
         ptr       <= '0;
         oe        <= 1'b0;
         regs_flat <= '0;
         wr_strobe <= 1'b0;
         wr_index  <= '0;
         busy      <= 1'b0;
      end else begin
         wr_strobe <= 1'b0;
         if (start || stop) begin
            state   <= start ? ADDR : IDLE;
            bit_cnt <= 4'd0;
            oe      <= 1'b0;
            busy    <= 1'b0;
         end else begin
            case (state)
               ADDR, PTR, WRITE: if (scl_rise) begin
                  shreg   <= data;
                  bit_cnt <= last ? 4'd8 : bit_cnt + 4'd1;
                  if (last && state == ADDR) begin
                     state <= data[7:1] == SLAVE_ADDR ? ADDR_ACK : IGNORE;
                     busy  <= data[7:1] == SLAVE_ADDR;
                  end
                  if (last && state == PTR) begin
                     ptr   <= data[IW-1:0];
                     state <= PTR_ACK;
                  end
                  if (last && state == WRITE) begin
                     regs_flat[{ptr, 3'b000} +: 8] <= data;
                     wr_strobe <= 1'b1;
                     wr_index  <= ptr;
                     ptr       <= ptr + IW'(1);
                     state     <= WRITE_ACK;
                  end
               end
               // First fall opens the ACK slot, second fall closes it
               ADDR_ACK, PTR_ACK, WRITE_ACK: if (scl_fall) begin
                  if (!oe) oe <= 1'b1;
                  else if (state == ADDR_ACK && shreg[0] == RW_READ) begin
                     state   <= READ;
                     bit_cnt <= 4'd0;
                     shreg   <= {cur[6:0], 1'b0};
                     oe      <= ~cur[7];
                  end else begin
                     state   <= state == ADDR_ACK && shreg[0] == RW_WRITE ? PTR : WRITE;
                     bit_cnt <= 4'd0;
                     oe      <= 1'b0;
                  end
               end
               READ: if (scl_fall) begin
                  oe    <= ~shreg[7];
                  shreg <= {shreg[6:0], 1'b0};
               end else if (scl_rise) begin
                  bit_cnt <= last ? 4'd8 : bit_cnt + 4'd1;
                  if (last) begin
                     ptr   <= ptr + IW'(1);
                     state <= READ_ACK;
                  end
               end
               READ_ACK: if (scl_fall) oe <= 1'b0;
               else if (scl_rise) begin
                  state   <= sda_q == NACK ? IGNORE : READ;
                  bit_cnt <= 4'd0;
                  shreg   <= cur;
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: bit-banged I2C master against a transaction-level register model
module tb_i2c_slave;
   localparam int N = 4;
   logic clk = 1'b0, rst = 1'b1, scl = 1'b1, m_oe = 1'b0;
   wire sda_w;
   logic [8*N-1:0] regs_flat;
   logic wr_strobe, busy;
   logic [1:0] wr_index;
   int checks = 0, failures = 0, dut_low = 0, busy_hits = 0, mptr = 0;
   logic [1:0] strobes[$], exp_q[$];
   logic [7:0] mregs[N];
   logic a, b;
   logic [7:0] rb;

   assign sda_w = m_oe ? 1'b0 : 1'bz;
   pullup (sda_w);

   i2c_slave #(.SLAVE_ADDR(7'h01), .NUM_REGS(N)) dut (
      .clk(clk), .rst(rst), .sclk(scl), .sda(sda_w),
      .regs_flat(regs_flat), .wr_strobe(wr_strobe), .wr_index(wr_index), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_strobe) strobes.push_back(wr_index);
      if (sda_w === 1'b0 && !m_oe) dut_low++;
      if (busy) busy_hits++;
   end

   task automatic w(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void mw(input logic [7:0] d);
      mregs[mptr] = d;
      exp_q.push_back(2'(mptr));
      mptr = (mptr + 1) % N;
   endfunction

   function automatic logic [7:0] mr();
      logic [7:0] r = mregs[mptr];
      mptr = (mptr + 1) % N;
      return r;
   endfunction

   function automatic logic [31:0] mflat();
      logic [31:0] r;
      for (int i = 0; i < N; i++) r[8*i +: 8] = mregs[i];
      return r;
   endfunction

   task automatic chk_strobes();
      chk("strobe_count", strobes.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < strobes.size(); i++) chk("wr_index", strobes[i], exp_q[i]);
      strobes.delete();
      exp_q.delete();
   endtask

   task automatic do_start();
      m_oe = 1'b0; w(4);
      scl = 1'b1; w(8);
      m_oe = 1'b1; w(8);
      scl = 1'b0; w(4);
   endtask

   task automatic do_stop();
      m_oe = 1'b1; w(4);
      scl = 1'b1; w(8);
      m_oe = 1'b0; w(8);
   endtask

   task automatic wbit(input logic v);
      m_oe = ~v; w(4);
      scl = 1'b1; w(8);
      scl = 1'b0; w(4);
   endtask

   task automatic rbit(output logic v);
      m_oe = 1'b0; w(4);
      scl = 1'b1; w(4);
      v = sda_w; w(4);
      scl = 1'b0; w(4);
   endtask

   task automatic send(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) wbit(d[i]);
      rbit(ack);
   endtask

   task automatic recv(output logic [7:0] d, input logic ackbit);
      logic v;
      for (int i = 7; i >= 0; i--) begin rbit(v); d[i] = v; end
      wbit(ackbit);
   endtask

   task automatic xwrite(input logic [7:0] p, input int n, input logic [23:0] d);
      logic k;
      do_start();
      send(8'h02, k); chk("wr_addr_ack", k, 1'b0);
      send(p, k); chk("wr_ptr_ack", k, 1'b0);
      mptr = p % N;
      for (int i = 0; i < n; i++) begin
         send(d[23-8*i -: 8], k); chk("wr_data_ack", k, 1'b0);
         mw(d[23-8*i -: 8]);
      end
      chk("busy_in_txn", busy, 1'b1);
      do_stop();
      chk("regs_after_write", regs_flat, mflat());
      chk_strobes();
   endtask

   task automatic xread(input bit setp, input logic [7:0] p, input int n);
      logic k;
      logic [7:0] d, e;
      do_start();
      if (setp) begin
         send(8'h02, k); chk("rd_waddr_ack", k, 1'b0);
         send(p, k); chk("rd_ptr_ack", k, 1'b0);
         mptr = p % N;
         do_start();
      end
      send(8'h03, k); chk("rd_addr_ack", k, 1'b0);
      for (int i = 0; i < n; i++) begin
         e = mr();
         recv(d, i == n - 1);
         chk("rd_data", d, e);
      end
      w(8);
      chk("rd_release_after_nack", sda_w, 1'b1);
      do_stop();
      chk("rd_busy_after_stop", busy, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < N; i++) mregs[i] = 8'h00;
      w(5);
      chk("rst_regs", regs_flat, 32'h0);
      chk("rst_strobe", wr_strobe, 1'b0);
      chk("rst_index", wr_index, 2'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_sda", sda_w, 1'b1);
      rst = 1'b0; w(10);
      // Addressed write, then read back across a repeated START
      xwrite(8'h01, 2, 24'hA53C00);
      xread(1'b1, 8'h01, 2);
      xread(1'b0, 8'h00, 1);
      // Address mismatch
      dut_low = 0; busy_hits = 0;
      do_start();
      send(8'h0A, a); chk("mis_addr_nack", a, 1'b1);
      send(8'hFF, a); chk("mis_data_nack", a, 1'b1);
      do_stop();
      chk("mis_sda_never_low", dut_low, 0);
      chk("mis_busy_never", busy_hits, 0);
      chk("mis_regs", regs_flat, mflat());
      chk_strobes();
      // Pointer wrap
      xwrite(8'h03, 2, 24'h112200);
      // Randomized writes and reads
      for (int t = 0; t < 4; t++) begin
         xwrite(8'($urandom_range(0, 255)), $urandom_range(1, 3), 24'($urandom));
         xread(1'b1, 8'($urandom_range(0, 255)), $urandom_range(1, 4));
      end
      // Reset mid-byte
      do_start();
      send(8'h02, a); send(8'h02, a);
      for (int i = 0; i < 4; i++) wbit(1'($urandom));
      rst = 1'b1; m_oe = 1'b0; w(1);
      chk("midrst_sda", sda_w, 1'b1);
      chk("midrst_regs", regs_flat, 32'h0);
      chk("midrst_busy", busy, 1'b0);
      w(2);
      rst = 1'b0; scl = 1'b1; w(12);
      for (int i = 0; i < N; i++) mregs[i] = 8'h00;
      mptr = 0;
      chk_strobes();
      xwrite(8'h00, 1, 24'h5A0000);
      xread(1'b1, 8'h00, 1);
      // STOP mid-byte
      do_start();
      send(8'h02, a); send(8'h01, a);
      mptr = 1;
      for (int i = 0; i < 5; i++) wbit(1'($urandom));
      do_stop();
      chk("midstop_regs", regs_flat, mflat());
      chk("midstop_busy", busy, 1'b0);
      chk_strobes();
      xread(1'b0, 8'h00, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
